// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN feature-map blocks.
// Helpers work at 32 bits so any data width up to 31 can use them.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_WR,
        S_FIN
    } pool_state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Add two sign-extended operands, then clamp to the signed dw-bit range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 dw
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] x);
        return (x < 0) ? 32'sd0 : x;
    endfunction

endpackage

// File: rtl/fmap_ram.sv
// Feature-map storage: C channels of N pixels, one write port and three
// registered read ports (two external, one for the pooling engine).
module fmap_ram
    import cnn_pkg::*;
#(
    parameter int C  = 8,
    parameter int N  = 784,
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int CW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [CW-1:0]        w_c,
    input  logic [AW-1:0]        w_a,
    input  logic signed [DW-1:0] w_d,
    input  logic [CW-1:0]        rd_c,
    input  logic [AW-1:0]        rd_a1,
    input  logic [AW-1:0]        rd_a2,
    input  logic [CW-1:0]        pool_c,
    input  logic [AW-1:0]        pool_a,
    output logic signed [DW-1:0] q1,
    output logic signed [DW-1:0] q2,
    output logic signed [DW-1:0] qp
);

    localparam int D  = C * N;
    localparam int MW = (D > 1) ? clog2(D) : 1;

    logic [DW-1:0] mem [D];
    logic [MW-1:0] wi;
    logic [MW-1:0] i1;
    logic [MW-1:0] i2;
    logic [MW-1:0] ip;

    assign wi = MW'(w_c) * MW'(N) + MW'(w_a);
    assign i1 = MW'(rd_c) * MW'(N) + MW'(rd_a1);
    assign i2 = MW'(rd_c) * MW'(N) + MW'(rd_a2);
    assign ip = MW'(pool_c) * MW'(N) + MW'(pool_a);

    always_ff @(posedge clk) begin
        if (we) mem[wi] <= w_d;
    end

    // Reads sample the array before this edge's write lands: old data wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q2 <= '0;
            qp <= '0;
        end else begin
            q1 <= $signed(mem[i1]);
            q2 <= $signed(mem[i2]);
            qp <= $signed(mem[ip]);
        end
    end

endmodule

// File: rtl/fmap_pool_mem.sv
// Layer-output feature-map memory with bias/saturate/ReLU on write and an
// in-place 2x2 stride-2 max-pool engine per channel.
module fmap_pool_mem
    import cnn_pkg::*;
#(
    parameter int H       = 28,
    parameter int W       = 28,
    parameter int C       = 8,
    parameter int DW      = 8,
    parameter int RELU_EN = 1,
    parameter int POOL_EN = 1,
    localparam int AW     = clog2(H * W),
    localparam int CW     = (C > 1) ? clog2(C) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store,
    input  logic [CW-1:0]        out_c,
    input  logic [AW-1:0]        w_addr,
    input  logic signed [DW-1:0] value,
    input  logic signed [DW-1:0] bias,
    input  logic                 cout_done,
    input  logic                 pool,
    output logic                 pool_done,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err,
    input  logic [CW-1:0]        rd_c,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic signed [DW-1:0] rd_data1,
    output logic signed [DW-1:0] rd_data2
);

    localparam int PH = H / 2;
    localparam int PW = W / 2;
    localparam int RW = (PH > 1) ? clog2(PH) : 1;
    localparam int XW = (PW > 1) ? clog2(PW) : 1;
    localparam int NW = clog2(C + 1);

    if ((H % 2) != 0 || (W % 2) != 0) begin : g_odd_dims
        $error("fmap_pool_mem: H and W must be even");
    end

    pool_state_t          state;
    logic [CW-1:0]        pc;
    logic [RW-1:0]        pr;
    logic [XW-1:0]        px;
    logic signed [DW-1:0] mx;
    logic signed [DW-1:0] mxn;
    logic signed [DW-1:0] qp;
    logic [NW-1:0]        cnt;
    logic                 pool_go;
    logic                 store_ok;
    logic                 inc;
    logic                 we;
    logic [CW-1:0]        w_c;
    logic [AW-1:0]        w_a;
    logic [AW-1:0]        pa;
    logic signed [DW-1:0] w_d;
    int                   off;

    assign pool_go  = pool && (POOL_EN != 0) && (state == S_IDLE);
    assign store_ok = store && (state == S_IDLE) && !pool_go
                      && (int'(out_c) < C);
    assign inc      = (POOL_EN != 0) ? (state == S_FIN) : cout_done;
    assign mxn      = (qp > mx) ? qp : mx;

    // Source pixel of the 2x2 window for the current read state.
    always_comb begin
        off = 0;
        case (state)
            S_RD1:   off = 1;
            S_RD2:   off = W;
            S_RD3:   off = W + 1;
            default: off = 0;
        endcase
        pa = AW'(2 * W * int'(pr) + 2 * int'(px) + off);
    end

    assign we  = store_ok || (state == S_WR);
    assign w_c = (state == S_WR) ? pc : out_c;
    assign w_a = (state == S_WR) ? AW'(int'(pr) * PW + int'(px)) : w_addr;
    assign w_d = (state == S_WR) ? mxn
               : DW'((RELU_EN != 0)
                     ? relu(sat_add(32'(value), 32'(bias), DW))
                     : sat_add(32'(value), 32'(bias), DW));

    fmap_ram #(
        .C (C),
        .N (H * W),
        .DW(DW),
        .AW(AW),
        .CW(CW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .w_c   (w_c),
        .w_a   (w_a),
        .w_d   (w_d),
        .rd_c  (rd_c),
        .rd_a1 (rd_addr1),
        .rd_a2 (rd_addr2),
        .pool_c(pc),
        .pool_a(pa),
        .q1    (rd_data1),
        .q2    (rd_data2),
        .qp    (qp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            pr         <= '0;
            px         <= '0;
            mx         <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            pool_done  <= 1'b0;
            layer_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            pool_done <= 1'b0;
            if (store && !store_ok) err <= 1'b1;
            if (inc && (cnt != NW'(C))) begin
                cnt <= cnt + NW'(1);
                if (cnt == NW'(C - 1)) layer_done <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pool_go) begin
                        pc    <= out_c;
                        pr    <= '0;
                        px    <= '0;
                        busy  <= 1'b1;
                        state <= S_RD0;
                    end
                end
                S_RD0: state <= S_RD1;
                S_RD1: begin
                    mx    <= qp;
                    state <= S_RD2;
                end
                S_RD2: begin
                    mx    <= mxn;
                    state <= S_RD3;
                end
                S_RD3: begin
                    mx    <= mxn;
                    state <= S_WR;
                end
                S_WR: begin
                    if (px == XW'(PW - 1)) begin
                        px <= '0;
                        if (pr == RW'(PH - 1)) begin
                            pr    <= '0;
                            state <= S_FIN;
                        end else begin
                            pr    <= pr + RW'(1);
                            state <= S_RD0;
                        end
                    end else begin
                        px    <= px + XW'(1);
                        state <= S_RD0;
                    end
                end
                S_FIN: begin
                    busy      <= 1'b0;
                    pool_done <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_pool_mem.sv
// Directed bench for fmap_pool_mem: one ReLU instance (C=2) and one
// linear instance (C=3) sharing clock and reset.
module tb_fmap_pool_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              store, cout_done, pool;
    logic [0:0]        out_c, rd_c;
    logic [3:0]        w_addr, rd_addr1, rd_addr2;
    logic signed [7:0] value, bias;
    logic              pool_done, busy, layer_done, err;
    logic signed [7:0] rd_data1, rd_data2;

    logic              b_store, b_cout_done, b_pool;
    logic [1:0]        b_out_c, b_rd_c;
    logic [3:0]        b_w_addr, b_rd_addr1, b_rd_addr2;
    logic signed [7:0] b_value, b_bias;
    logic              b_pool_done, b_busy, b_layer_done, b_err;
    logic signed [7:0] b_rd_data1, b_rd_data2;

    int checks = 0;
    int errors = 0;
    int done_at;
    int bc;
    logic ld_at_done;

    fmap_pool_mem #(
        .H(4), .W(4), .C(2), .DW(8), .RELU_EN(1), .POOL_EN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .store(store), .out_c(out_c),
        .w_addr(w_addr), .value(value), .bias(bias),
        .cout_done(cout_done), .pool(pool), .pool_done(pool_done),
        .busy(busy), .layer_done(layer_done), .err(err),
        .rd_c(rd_c), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2)
    );

    fmap_pool_mem #(
        .H(4), .W(4), .C(3), .DW(8), .RELU_EN(0), .POOL_EN(1)
    ) dut_b (
        .clk(clk), .rst(rst), .store(b_store), .out_c(b_out_c),
        .w_addr(b_w_addr), .value(b_value), .bias(b_bias),
        .cout_done(b_cout_done), .pool(b_pool), .pool_done(b_pool_done),
        .busy(b_busy), .layer_done(b_layer_done), .err(b_err),
        .rd_c(b_rd_c), .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2),
        .rd_data1(b_rd_data1), .rd_data2(b_rd_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic a_wr(input int c, input int a, input int v, input int b);
        store = 1'b1; out_c = 1'(c); w_addr = 4'(a);
        value = 8'(v); bias = 8'(b);
        tick();
        store = 1'b0;
    endtask

    task automatic a_rd(input int c, input int a1, input int a2);
        rd_c = 1'(c); rd_addr1 = 4'(a1); rd_addr2 = 4'(a2);
        tick();
    endtask

    task automatic b_wr(input int c, input int a, input int v, input int b);
        b_store = 1'b1; b_out_c = 2'(c); b_w_addr = 4'(a);
        b_value = 8'(v); b_bias = 8'(b);
        tick();
        b_store = 1'b0;
    endtask

    task automatic b_rd(input int c, input int a1, input int a2);
        b_rd_c = 2'(c); b_rd_addr1 = 4'(a1); b_rd_addr2 = 4'(a2);
        tick();
    endtask

    // Pool a channel of dut_a; a stray pool pulse at cycle 3 must be ignored.
    task automatic a_pool(input int c);
        out_c = 1'(c); pool = 1'b1;
        tick();
        pool = 1'b0;
        done_at = 0; bc = 0; ld_at_done = 1'b0;
        for (int cyc = 1; cyc < 80 && done_at == 0; cyc++) begin
            if (busy) bc++;
            if (pool_done) begin
                done_at = cyc;
                ld_at_done = layer_done;
            end
            pool = (cyc == 3);
            tick();
        end
        pool = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        store = 0; cout_done = 0; pool = 0; out_c = 0; rd_c = 0;
        w_addr = 0; rd_addr1 = 0; rd_addr2 = 0; value = 0; bias = 0;
        b_store = 0; b_cout_done = 0; b_pool = 0; b_out_c = 0; b_rd_c = 0;
        b_w_addr = 0; b_rd_addr1 = 0; b_rd_addr2 = 0; b_value = 0; b_bias = 0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_pool_done", pool_done, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data1", rd_data1, 0);
        chk("rst_b_err", b_err, 0);
        rst = 1'b0;
        tick();

        // bias add with saturation and ReLU
        a_wr(0, 0, 100, 50);
        a_wr(0, 1, -10, 3);
        a_rd(0, 0, 1);
        chk("sat_pos_relu", rd_data1, 127);
        chk("relu_neg", rd_data2, 0);

        // ramp in ch0, reversed ramp in ch1
        for (int i = 0; i < 16; i++) a_wr(0, i, i, 0);
        for (int i = 0; i < 16; i++) a_wr(1, i, 15 - i, 0);

        a_pool(0);
        chk("pool0_latency", done_at, 22);
        chk("pool0_busy_cycles", bc, 21);
        chk("pool0_done_pulse", pool_done, 0);
        chk("pool0_layer_done", layer_done, 0);
        a_rd(0, 0, 1);
        chk("pool0_idx0", rd_data1, 5);
        chk("pool0_idx1", rd_data2, 7);
        a_rd(0, 2, 3);
        chk("pool0_idx2", rd_data1, 13);
        chk("pool0_idx3", rd_data2, 15);

        a_pool(1);
        chk("pool1_latency", done_at, 22);
        chk("layer_done_with_pool_done", ld_at_done, 1);
        a_rd(1, 0, 1);
        chk("pool1_idx0", rd_data1, 15);
        chk("pool1_idx1", rd_data2, 13);
        a_rd(1, 2, 3);
        chk("pool1_idx2", rd_data1, 7);
        chk("pool1_idx3", rd_data2, 5);

        // back-to-back reads, both ports, channel switch
        a_rd(0, 4, 15);
        chk("b2b_p1_a", rd_data1, 4);
        chk("b2b_p2_a", rd_data2, 15);
        a_rd(0, 9, 6);
        chk("b2b_p1_b", rd_data1, 9);
        chk("b2b_p2_b", rd_data2, 6);
        a_rd(1, 8, 0);
        chk("b2b_p1_c", rd_data1, 7);
        chk("b2b_p2_c", rd_data2, 15);

        // same-cycle read and write of one cell returns the old value
        rd_c = 0; rd_addr1 = 5;
        a_wr(0, 5, 20, 0);
        chk("raw_old", rd_data1, 5);
        tick();
        chk("raw_new", rd_data1, 20);

        cout_done = 1'b1;
        tick();
        cout_done = 1'b0;
        chk("layer_done_held", layer_done, 1);
        chk("a_err_clean", err, 0);

        // reset in the middle of a pool
        out_c = 0; pool = 1'b1;
        tick();
        pool = 1'b0;
        repeat (4) tick();
        chk("midpool_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_pool_done", pool_done, 0);
        chk("midrst_layer_done", layer_done, 0);
        rst = 1'b0;
        tick();

        // linear instance: saturation both ways, no ReLU
        chk("b_err_after_rst", b_err, 0);
        b_wr(2, 0, -100, -100);
        b_wr(2, 1, 100, 100);
        b_wr(2, 2, -10, 3);
        b_rd(2, 0, 1);
        chk("b_sat_neg", b_rd_data1, -128);
        chk("b_sat_pos", b_rd_data2, 127);
        b_rd(2, 2, 2);
        chk("b_no_relu", b_rd_data1, -7);

        // signed max; a store dropped mid-pool must not land
        b_wr(0, 0, -5, 0);
        b_wr(0, 1, -2, 0);
        b_wr(0, 4, -8, 0);
        b_wr(0, 5, -3, 0);
        b_out_c = 0; b_pool = 1'b1;
        tick();
        b_pool = 1'b0;
        done_at = 0;
        for (int cyc = 1; cyc < 80 && done_at == 0; cyc++) begin
            if (b_pool_done) done_at = cyc;
            b_store = (cyc == 10);
            b_w_addr = 4'd0; b_value = 8'sd50; b_bias = 8'sd0;
            tick();
        end
        b_store = 1'b0;
        chk("b_pool_latency", done_at, 22);
        chk("b_err_busy_store", b_err, 1);
        chk("b_layer_done_partial", b_layer_done, 0);
        b_rd(0, 0, 0);
        chk("b_signed_max", b_rd_data1, -2);

        // channel index out of range
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("b_err_cleared", b_err, 0);
        b_wr(3, 6, 1, 1);
        chk("b_err_bad_ch", b_err, 1);
        repeat (3) tick();
        chk("b_err_sticky", b_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
